sm_trace_buffer: RTL and testbench
==================================

// Module: sm_trace_buffer
// PURPOSE
//  Parametrised on-chip instruction trace recorder for the schoolMIPS core.
//  Captures {cycle stamp, PC, instr} per executed CPU cycle into a circular buffer.
//  Supports a programmable trigger, a post-trigger window and a cycle timeout.
//  Freezes the capture for readout by a bench or a debug port.
//  Sits beside sm_cpu in sm_top; it is fed from the PC and instruction fetch signals.
// PARAMETERS
//  DEPTH     16   entries in circular buffer; power of 2, >=2
//  POST_TRIG 8    samples stored after the trigger sample; 0..DEPTH-1
//  TIMEOUT   120  sampled cycles before forced stop; 0 = disabled
//  AW        $clog2(DEPTH)  index width (derived, not overridden)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  en         in   1   sample qualifier: CPU cycle valid (cpu clock enable)
//  pc         in   32  current PC (word address)
//  instr      in   32  current instruction
//  arm        in   1   1-cycle pulse: clear buffer and start capture
//  trig_mode  in   2   0=immediate, 1=PC match, 2=instr match, 3=never (timeout only)
//  trig_value in   32  compare value for modes 1/2
//  rd_idx     in   AW  read index, 0 = oldest stored entry
//  rd_cycle   out  32  cycle stamp of entry rd_idx
//  rd_pc      out  32  PC of entry rd_idx
//  rd_instr   out  32  instr of entry rd_idx
//  count      out  AW+1 valid entries, saturates at DEPTH
//  armed      out  1   state is ARMED or POST
//  triggered  out  1   trigger seen since last arm (sticky)
//  done       out  1   state is DONE
//  timeout    out  1   sticky; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; wr_ptr, post counter and cycle counter are 0.
//  Cycle counter (32b, wraps) increments on every en=1 clock in any state.
//  The counter is not cleared by arm. The stamp stored is the pre-increment value.
//  States:
//   IDLE->ARMED on arm. Also ARMED/POST/DONE->ARMED on arm.
//   Every arm clears count, wr_ptr and triggered.
//   Sample: en=1 in ARMED or POST. It writes {cycle, pc, instr} at wr_ptr.
//   wr_ptr advances mod DEPTH; count +1, saturating at DEPTH (oldest overwritten).
//   ARMED: the sample matching the trigger is stored, sets triggered and loads
//   post_cnt=POST_TRIG. The state goes to POST, or to DONE if POST_TRIG=0.
//   Mode 0 triggers on the first sample. Mode 3 never triggers.
//   POST: each sample decrements post_cnt; the sample that takes it to 0 -> DONE.
//   DONE: no writes; buffer frozen until next arm.
//  Timeout: when TIMEOUT!=0 and a sample is taken with cycle==TIMEOUT-1:
//   timeout=1 next clock and the state is forced to DONE. That sample is stored.
//   While timeout=1, arm is ignored.
//  Simultaneous arm and sample: arm wins; the sample is discarded.
//  Trigger and timeout on the same sample: both flags set; the state goes to DONE.
//  Readout: entry = mem[(wr_ptr - count + rd_idx) mod DEPTH].
//   rd_* are registered with 1-cycle latency from rd_idx, and are valid in any state.
//   rd_idx >= count returns stale data (undefined content, no error).
//  Reset mid-capture: returns to IDLE immediately; buffer contents are undefined.
//  All flags and status outputs are registered.
// TESTING
//  T1 mode0: arm, then 5 samples at pc=0..4 with POST_TRIG=4 -> done after sample 5;
//     count=5; rd_idx0 pc=0, idx4 pc=4.
//  T2 mode1, trig_value=10, DEPTH=16, POST_TRIG=8: feed pc=0..40 ->
//     done; count=16; idx7 pc=10 (trigger); idx15 pc=18.
//  T3 wrap: mode3, TIMEOUT=0, 40 samples -> count=16; idx0 pc=24; never done.
//     Then arm -> count=0, triggered=0.
//  T4 timeout: TIMEOUT=20, mode3, en every clock from reset, armed at cycle 0 ->
//     timeout=1 and done=1 after the sample stamped 19. A later arm is ignored.
//  T5 arm on the same clock as an en=1 sample -> count stays 0 that cycle.
//     en gaps: samples are skipped and stamps stay consecutive.
//  T6 async reset asserted in POST -> all outputs 0 without a clock edge;
//     rd_* read back 0 after release.

Source files
------------

// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: circular instruction trace recorder for the schoolMIPS core.
// Captures {cycle, pc, instr} per CPU cycle, with trigger, post-trigger window and timeout.
module sm_trace_buffer #(
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned POST_TRIG = 8,
  parameter  int unsigned TIMEOUT   = 120,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
  input  logic          arm,
  input  logic [1:0]    trig_mode,
  input  logic [31:0]   trig_value,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_cycle,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_instr,
  output logic [AW:0]   count,
  output logic          armed,
  output logic          triggered,
  output logic          done,
  output logic          timeout
);

  localparam logic          TO_EN     = (TIMEOUT != 0);
  localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT - 1);
  localparam logic          POST_NONE = (POST_TRIG == 0);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE} state_t;

  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic          triggered_q, triggered_d;
  logic          timeout_q, timeout_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;
  entry_t        rd_q, rd_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          hit;
  logic [AW-1:0] rd_addr;

  // Next-state, capture and readout logic
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    timeout_d   = timeout_q;
    mem_d       = mem_q;
    hit         = 1'b0;
    rd_addr     = '0;

    if (en) cycle_d = cycle_q + 32'd1;

    if (arm && !timeout_q) begin
      state_d     = ST_ARMED;
      count_d     = '0;
      wr_ptr_d    = '0;
      triggered_d = 1'b0;
    end else if (en && (state_q == ST_ARMED || state_q == ST_POST)) begin
      mem_d[wr_ptr_q] = '{cycle: cycle_q, pc: pc, instr: instr};
      wr_ptr_d        = wr_ptr_q + AW'(1);
      if (count_q != CNT_FULL) count_d = count_q + (AW+1)'(1);

      if (state_q == ST_ARMED) begin
        unique case (trig_mode)
          2'd0:    hit = 1'b1;
          2'd1:    hit = (pc == trig_value);
          2'd2:    hit = (instr == trig_value);
          default: hit = 1'b0;
        endcase
        if (hit) begin
          triggered_d = 1'b1;
          post_cnt_d  = AW'(POST_TRIG);
          state_d     = POST_NONE ? ST_DONE : ST_POST;
        end
      end else begin
        post_cnt_d = post_cnt_q - AW'(1);
        if (post_cnt_q == AW'(1)) state_d = ST_DONE;
      end

      // Timeout overrides whatever the trigger logic decided
      if (TO_EN && cycle_q == TO_LAST) begin
        timeout_d = 1'b1;
        state_d   = ST_DONE;
      end
    end

    armed_d = (state_d == ST_ARMED) || (state_d == ST_POST);
    done_d  = (state_d == ST_DONE);

    // count is at most DEPTH, so truncation to AW bits gives the modulo
    rd_addr = wr_ptr_q - AW'(count_q) + rd_idx;
    rd_d    = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cycle_q     <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      timeout_q   <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      timeout_q   <= timeout_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      mem_q       <= mem_d;
    end
  end

  assign rd_cycle  = rd_q.cycle;
  assign rd_pc     = rd_q.pc;
  assign rd_instr  = rd_q.instr;
  assign count     = count_q;
  assign armed     = armed_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// tb_sm_trace_buffer: directed, table-driven and randomized checks of sm_trace_buffer.
// dut_a: POST_TRIG=8, no timeout (model-checked); dut_b: POST_TRIG=4, TIMEOUT=20.
`timescale 1ns/1ps
module tb_sm_trace_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int          POST_A = 8;

  logic          clk = 1'b0;
  logic          rst_a_n, rst_b_n, en, arm;
  logic [31:0]   pc, instr, trig_value;
  logic [1:0]    trig_mode;
  logic [AW-1:0] rd_idx;

  logic [31:0] a_rd_cycle, a_rd_pc, a_rd_instr, b_rd_cycle, b_rd_pc, b_rd_instr;
  logic [AW:0] a_count, b_count;
  logic        a_armed, a_triggered, a_done, a_timeout;
  logic        b_armed, b_triggered, b_done, b_timeout;

  sm_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(8), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .en(en), .pc(pc), .instr(instr), .arm(arm),
    .trig_mode(trig_mode), .trig_value(trig_value), .rd_idx(rd_idx),
    .rd_cycle(a_rd_cycle), .rd_pc(a_rd_pc), .rd_instr(a_rd_instr), .count(a_count),
    .armed(a_armed), .triggered(a_triggered), .done(a_done), .timeout(a_timeout));

  sm_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(4), .TIMEOUT(20)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .en(en), .pc(pc), .instr(instr), .arm(arm),
    .trig_mode(trig_mode), .trig_value(trig_value), .rd_idx(rd_idx),
    .rd_cycle(b_rd_cycle), .rd_pc(b_rd_pc), .rd_instr(b_rd_instr), .count(b_count),
    .armed(b_armed), .triggered(b_triggered), .done(b_done), .timeout(b_timeout));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_model = 1'b0;

  // Reference model of dut_a: a list of stored samples plus capture phase
  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        mq[$];
  int          m_phase;   // 0 idle, 1 waiting for trigger, 2 post window, 3 frozen
  int          m_left;
  bit          m_trig;
  logic [31:0] m_cyc;

  typedef struct {
    int          idx;
    logic [31:0] pc;
  } rd_vec_t;
  rd_vec_t tab[5];

  function automatic logic [31:0] ins(input logic [31:0] k);
    return 32'hC0DE_0000 | k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void m_reset();
    mq.delete();
    m_phase = 0;
    m_left  = 0;
    m_trig  = 1'b0;
    m_cyc   = '0;
  endfunction

  function automatic void m_step(input logic a, input logic e, input logic [31:0] p,
                                 input logic [31:0] i, input logic [1:0] mode,
                                 input logic [31:0] tv);
    if (a) begin
      mq.delete();
      m_trig  = 1'b0;
      m_phase = 1;
    end else if (e && (m_phase == 1 || m_phase == 2)) begin
      mq.push_back('{cyc: m_cyc, pc: p, instr: i});
      if (mq.size() > DEPTH) void'(mq.pop_front());
      if (m_phase == 1) begin
        if (mode == 2'd0 || (mode == 2'd1 && p == tv) || (mode == 2'd2 && i == tv)) begin
          m_trig  = 1'b1;
          m_left  = POST_A;
          m_phase = 2;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
    end
    if (e) m_cyc = m_cyc + 32'd1;
  endfunction

  // One clock: drive at negedge, sample after posedge, return at next negedge
  task automatic step(input logic a, input logic e, input logic [31:0] p, input logic [31:0] i);
    ent_t exp_e;
    bit   rd_ok;
    exp_e = '0;
    arm = a; en = e; pc = p; instr = i;
    rd_ok = (int'(rd_idx) < mq.size());
    if (rd_ok) exp_e = mq[rd_idx];
    m_step(a, e, p, i, trig_mode, trig_value);
    @(posedge clk);
    #1;
    if (chk_model) begin
      chk("m_count", 32'(a_count), 32'(mq.size()));
      chk("m_armed", 32'(a_armed), 32'(m_phase == 1 || m_phase == 2));
      chk("m_triggered", 32'(a_triggered), 32'(m_trig));
      chk("m_done", 32'(a_done), 32'(m_phase == 3));
      chk("m_timeout", 32'(a_timeout), 32'd0);
      if (rd_ok) begin
        chk("m_rd_cycle", a_rd_cycle, exp_e.cyc);
        chk("m_rd_pc", a_rd_pc, exp_e.pc);
        chk("m_rd_instr", a_rd_instr, exp_e.instr);
      end
    end
    arm = 1'b0; en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] base;
    tab[0] = '{idx: 0,  pc: 32'd3};
    tab[1] = '{idx: 1,  pc: 32'd4};
    tab[2] = '{idx: 7,  pc: 32'd10};
    tab[3] = '{idx: 8,  pc: 32'd11};
    tab[4] = '{idx: 15, pc: 32'd18};

    rst_a_n = 1'b0; rst_b_n = 1'b0; en = 1'b0; arm = 1'b0; pc = '0; instr = '0;
    trig_mode = '0; trig_value = '0; rd_idx = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_a_armed", 32'(a_armed), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_rd_pc", a_rd_pc, 32'd0);
    chk("rst_b_timeout", 32'(b_timeout), 32'd0);
    chk("rst_b_triggered", 32'(b_triggered), 32'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);
    chk_model = 1'b1;

    // T4: timeout on dut_b; arm coincides with the cycle-0 sample
    trig_mode = 2'd3;
    step(1'b1, 1'b1, 32'd0, ins(32'd0));
    chk("t4_arm_count", 32'(b_count), 32'd0);
    chk("t4_arm_armed", 32'(b_armed), 32'd1);
    for (int k = 1; k <= 19; k++) begin
      step(1'b0, 1'b1, 32'(k), ins(32'(k)));
      if (k == 18) begin
        chk("t4_pre_timeout", 32'(b_timeout), 32'd0);
        chk("t4_pre_done", 32'(b_done), 32'd0);
      end
    end
    chk("t4_timeout", 32'(b_timeout), 32'd1);
    chk("t4_done", 32'(b_done), 32'd1);
    chk("t4_armed", 32'(b_armed), 32'd0);
    chk("t4_count", 32'(b_count), 32'd16);
    rd_idx = 4'd15;
    step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t4_rd15_cycle", b_rd_cycle, 32'd19);
    chk("t4_rd15_pc", b_rd_pc, 32'd19);
    rd_idx = 4'd0;
    step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t4_rd0_pc", b_rd_pc, 32'd4);
    step(1'b1, 1'b0, 32'd0, 32'd0);
    chk("t4_arm_ignored_done", 32'(b_done), 32'd1);
    chk("t4_arm_ignored_armed", 32'(b_armed), 32'd0);
    chk("t4_arm_ignored_count", 32'(b_count), 32'd16);

    rst_b_n = 1'b0;
    @(negedge clk);
    chk("t4_reset_timeout", 32'(b_timeout), 32'd0);
    rst_b_n = 1'b1;

    // T1: immediate trigger on dut_b, 4 post samples
    trig_mode = 2'd0;
    step(1'b1, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k <= 4; k++) begin
      step(1'b0, 1'b1, 32'(k), ins(32'(k)));
      if (k == 3) chk("t1_done_early", 32'(b_done), 32'd0);
    end
    chk("t1_done", 32'(b_done), 32'd1);
    chk("t1_count", 32'(b_count), 32'd5);
    chk("t1_triggered", 32'(b_triggered), 32'd1);
    rd_idx = 4'd0;
    step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t1_rd0_pc", b_rd_pc, 32'd0);
    chk("t1_rd0_cycle", b_rd_cycle, 32'd0);
    rd_idx = 4'd4;
    step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t1_rd4_pc", b_rd_pc, 32'd4);
    chk("t1_rd4_instr", b_rd_instr, ins(32'd4));

    // T2: PC-match trigger on dut_a, window wraps the buffer
    trig_mode = 2'd1; trig_value = 32'd10;
    step(1'b1, 1'b0, 32'd0, 32'd0);
    base = m_cyc;
    for (int k = 0; k <= 40; k++) begin
      step(1'b0, 1'b1, 32'(k), ins(32'(k)));
      if (k == 17) chk("t2_done_early", 32'(a_done), 32'd0);
      if (k == 18) chk("t2_done_at18", 32'(a_done), 32'd1);
    end
    chk("t2_done", 32'(a_done), 32'd1);
    chk("t2_count", 32'(a_count), 32'd16);
    chk("t2_triggered", 32'(a_triggered), 32'd1);
    for (int j = 0; j < 5; j++) begin
      rd_idx = AW'(tab[j].idx);
      step(1'b0, 1'b0, 32'd0, 32'd0);
      chk("t2_tab_pc", a_rd_pc, tab[j].pc);
      chk("t2_tab_cycle", a_rd_cycle, base + tab[j].pc);
      chk("t2_tab_instr", a_rd_instr, ins(tab[j].pc));
    end

    // T3: never-trigger wrap on dut_a, then re-arm
    trig_mode = 2'd3;
    step(1'b1, 1'b0, 32'd0, 32'd0);
    chk("t3_arm_triggered", 32'(a_triggered), 32'd0);
    chk("t3_arm_count", 32'(a_count), 32'd0);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 32'(k), ins(32'(k)));
    chk("t3_count", 32'(a_count), 32'd16);
    chk("t3_done", 32'(a_done), 32'd0);
    chk("t3_armed", 32'(a_armed), 32'd1);
    rd_idx = 4'd0;
    step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t3_rd0_pc", a_rd_pc, 32'd24);
    step(1'b1, 1'b0, 32'd0, 32'd0);
    chk("t3_rearm_count", 32'(a_count), 32'd0);
    chk("t3_rearm_triggered", 32'(a_triggered), 32'd0);

    // T5: arm with simultaneous sample, then en gaps
    step(1'b1, 1'b1, 32'd100, ins(32'd100));
    chk("t5_arm_sample_count", 32'(a_count), 32'd0);
    base = m_cyc;
    for (int k = 0; k < 6; k++)
      step(1'b0, (k == 0 || k == 3 || k == 5), 32'(200 + k), ins(32'(200 + k)));
    chk("t5_count", 32'(a_count), 32'd3);
    for (int j = 0; j < 3; j++) begin
      rd_idx = AW'(j);
      step(1'b0, 1'b0, 32'd0, 32'd0);
      chk("t5_stamp", a_rd_cycle, base + 32'(j));
    end
    chk("t5_last_pc", a_rd_pc, 32'd205);

    // T6: async reset while in the post window
    trig_mode = 2'd0; rd_idx = 4'd0;
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b1, 32'd1, ins(32'd1));
    step(1'b0, 1'b1, 32'd2, ins(32'd2));
    chk("t6_in_post", 32'(a_armed), 32'd1);
    #2;
    rst_a_n = 1'b0;
    m_reset();
    #1;
    chk("t6_async_armed", 32'(a_armed), 32'd0);
    chk("t6_async_triggered", 32'(a_triggered), 32'd0);
    chk("t6_async_count", 32'(a_count), 32'd0);
    chk("t6_async_rd_pc", a_rd_pc, 32'd0);
    chk("t6_async_rd_cycle", a_rd_cycle, 32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rd_idx = 4'd3;
    step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t6_post_rd_pc", a_rd_pc, 32'd0);
    chk("t6_post_rd_instr", a_rd_instr, 32'd0);
    chk("t6_post_done", 32'(a_done), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      trig_mode  = 2'($urandom_range(0, 3));
      trig_value = 32'($urandom_range(0, 15));
      rd_idx     = AW'($urandom_range(0, 15));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
